// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: groups the EX-stage sequencing signals of pipe_ctrl.
//   Signal names carry the direction as seen from pipe_ctrl (_i = into the
//   sequencer, _o = out of it).
//   slave  : used by pipe_ctrl (consumes requests, drives redirect/flush/hold)
//   master : used by the surrounding pipeline / testbench
//   Requests : jump_en_i, jump_addr_i[31:0], hold_flag_ex_i, hold_req_bus_i
//   Controls : jump_en_o, jump_addr_o[31:0], flush_if_id_o, flush_id_ex_o,
//              hold_pc_o, hold_if_id_o, hold_id_ex_o, bus_grant_o, timeout_o
interface pipe_ctrl_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_ex_i;
  logic        hold_req_bus_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        bus_grant_o;
  logic        timeout_o;

  modport slave (
    input  jump_en_i, jump_addr_i, hold_flag_ex_i, hold_req_bus_i,
    output jump_en_o, jump_addr_o, flush_if_id_o, flush_id_ex_o,
           hold_pc_o, hold_if_id_o, hold_id_ex_o, bus_grant_o, timeout_o
  );

  modport master (
    output jump_en_i, jump_addr_i, hold_flag_ex_i, hold_req_bus_i,
    input  jump_en_o, jump_addr_o, flush_if_id_o, flush_id_ex_o,
           hold_pc_o, hold_if_id_o, hold_id_ex_o, bus_grant_o, timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: EX-stage pipeline sequencer. Arbitrates a taken jump, multi-cycle
// EX holds and external bus freezes; drives redirect to pc_reg and
// flush/hold to if_id and id_ex. Runaway EX holds are cut off after
// HOLD_TIMEOUT cycles and flagged on a sticky timeout_o.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   pif : pipe_ctrl_if.slave (requests in, redirect/flush/hold/grant out)
// Redirect, flush and hold outputs are Mealy (state + same-cycle inputs);
// bus_grant_o and timeout_o are registered.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned HOLD_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  pif
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    EX_HOLD,
    BUS_HOLD
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] FLUSH_INIT  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(HOLD_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_mask_q, ex_mask_d;
  logic             grant_q, grant_d;
  logic             timeout_q, timeout_d;

  logic             hold_ex;
  logic             do_jump;
  logic             do_flush;
  logic             do_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ex_mask_q <= 1'b0;
      grant_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_mask_q <= ex_mask_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    // The mask survives only while EX keeps requesting; one deassertion re-arms it.
    ex_mask_d = pif.hold_flag_ex_i ? ex_mask_q : 1'b0;
    grant_d   = grant_q;
    timeout_d = timeout_q;
    do_jump   = 1'b0;
    do_flush  = 1'b0;
    do_hold   = 1'b0;
    hold_ex   = pif.hold_flag_ex_i & ~ex_mask_q;

    case (state_q)
      RUN: begin
        if (pif.jump_en_i) begin
          do_jump  = 1'b1;
          do_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (hold_ex) begin
          do_hold = 1'b1;
          state_d = EX_HOLD;
          cnt_d   = CNT_ONE;
        end else if (pif.hold_req_bus_i) begin
          state_d = BUS_HOLD;
          grant_d = 1'b1;
        end
      end

      FLUSH: begin
        do_flush = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (cnt_q <= CNT_ONE) begin
          state_d = RUN;
        end
      end

      EX_HOLD: begin
        if (pif.hold_flag_ex_i) begin
          if (cnt_q == TIMEOUT_CNT) begin
            // Forced release: holds drop in this same cycle.
            timeout_d = 1'b1;
            ex_mask_d = 1'b1;
            state_d   = RUN;
          end else begin
            do_hold = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end else begin
          state_d = RUN;
          // Release cycle behaves like RUN for a jump; bus requests wait a cycle.
          if (pif.jump_en_i) begin
            do_jump  = 1'b1;
            do_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_INIT;
            end
          end
        end
      end

      BUS_HOLD: begin
        // EX is frozen here, so a jump request simply re-presents after release.
        do_hold = 1'b1;
        if (!pif.hold_req_bus_i) begin
          state_d = RUN;
          grant_d = 1'b0;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Mealy outputs are gated by rst so an asserted reset silences them at once,
  // even if requests are still present on the inputs.
  always_comb begin
    pif.jump_en_o     = do_jump & ~rst;
    pif.jump_addr_o   = (do_jump && !rst) ? pif.jump_addr_i : '0;
    pif.flush_if_id_o = do_flush & ~rst;
    pif.flush_id_ex_o = do_flush & ~rst;
    pif.hold_pc_o     = do_hold & ~rst;
    pif.hold_if_id_o  = do_hold & ~rst;
    pif.hold_id_ex_o  = do_hold & ~rst;
    pif.bus_grant_o   = grant_q;
    pif.timeout_o     = timeout_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed, scoreboard-checked bench for pipe_ctrl.
//   dut_a : FLUSH_CYCLES=1, HOLD_TIMEOUT=8   (single-cycle flush, short timeout)
//   dut_b : FLUSH_CYCLES=3, HOLD_TIMEOUT=255 (multi-cycle flush)
// Each step drives inputs just after a rising edge, queues the expected output
// vector, and compares it on the following falling edge.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_ctrl_if ifa ();
  pipe_ctrl_if ifb ();

  pipe_ctrl #(.FLUSH_CYCLES(1), .HOLD_TIMEOUT(8), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .pif (ifa)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .HOLD_TIMEOUT(255), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .pif (ifb)
  );

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  typedef struct {
    string       tag;
    bit          sel;
    logic [39:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  // Expected vector: {jump_en, addr, flush_if_id, flush_id_ex, hold_pc,
  // hold_if_id, hold_id_ex, grant, timeout}
  function automatic logic [39:0] ev(bit je, logic [31:0] ad, bit fl, bit hd,
                                     bit gr, bit to);
    return {je, ad, fl, fl, hd, hd, hd, gr, to};
  endfunction

  function automatic logic [39:0] obs(bit sel);
    if (sel)
      return {ifb.jump_en_o, ifb.jump_addr_o, ifb.flush_if_id_o, ifb.flush_id_ex_o,
              ifb.hold_pc_o, ifb.hold_if_id_o, ifb.hold_id_ex_o, ifb.bus_grant_o,
              ifb.timeout_o};
    return {ifa.jump_en_o, ifa.jump_addr_o, ifa.flush_if_id_o, ifa.flush_id_ex_o,
            ifa.hold_pc_o, ifa.hold_if_id_o, ifa.hold_id_ex_o, ifa.bus_grant_o,
            ifa.timeout_o};
  endfunction

  task automatic drive(bit sel, bit je, logic [31:0] ad, bit hf, bit hr);
    if (sel) begin
      ifb.jump_en_i      = je;
      ifb.jump_addr_i    = ad;
      ifb.hold_flag_ex_i = hf;
      ifb.hold_req_bus_i = hr;
    end else begin
      ifa.jump_en_i      = je;
      ifa.jump_addr_i    = ad;
      ifa.hold_flag_ex_i = hf;
      ifa.hold_req_bus_i = hr;
    end
  endtask

  task automatic push_exp(string tag, bit sel, logic [39:0] e);
    sb_t s;
    s.tag = tag;
    s.sel = sel;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic check_all();
    sb_t         s;
    logic [39:0] o;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      o = obs(s.sel);
      n_checks++;
      assert (o === s.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", s.tag, o, s.exp);
      end
    end
  endtask

  // One clock cycle: drive after the edge, compare on the falling edge.
  task automatic cyc(bit sel, bit je, logic [31:0] ad, bit hf, bit hr,
                     string tag, logic [39:0] e);
    @(posedge clk);
    #1;
    drive(sel, je, ad, hf, hr);
    push_exp(tag, sel, e);
    @(negedge clk);
    check_all();
  endtask

  // Mid-cycle reset pulse; inputs are cleared while rst is high.
  task automatic rst_pulse(bit sel, string tag);
    #1 rst = 1'b1;
    #1;
    push_exp(tag, sel, ev(0, '0, 0, 0, 0, 0));
    check_all();
    drive(sel, 0, '0, 0, 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(A, 0, '0, 0, 0);
    drive(B, 0, '0, 0, 0);
    #2;
    push_exp("reset_a", A, ev(0, '0, 0, 0, 0, 0));
    push_exp("reset_b", B, ev(0, '0, 0, 0, 0, 0));
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle flush jump (dut_a)
    cyc(A, 1, 32'h0000_0040, 0, 0, "t1_jump",     ev(1, 32'h40, 1, 0, 0, 0));
    cyc(A, 0, 32'h0000_0040, 0, 0, "t1_after",    ev(0, '0, 0, 0, 0, 0));
    cyc(A, 0, 32'hDEAD_BEEF, 0, 0, "t1_addr_0",   ev(0, '0, 0, 0, 0, 0));

    // Three-cycle flush; jump held, EX hold ignored during FLUSH (dut_b)
    cyc(B, 1, 32'h0000_0100, 0, 0, "t2_c0",       ev(1, 32'h100, 1, 0, 0, 0));
    cyc(B, 1, 32'h0000_0100, 1, 0, "t2_c1",       ev(0, '0, 1, 0, 0, 0));
    cyc(B, 1, 32'h0000_0100, 0, 0, "t2_c2",       ev(0, '0, 1, 0, 0, 0));
    cyc(B, 0, '0,            0, 0, "t2_c3",       ev(0, '0, 0, 0, 0, 0));

    // Bus request during FLUSH waits until RUN (dut_b)
    cyc(B, 1, 32'h0000_0200, 0, 1, "tf_jump",     ev(1, 32'h200, 1, 0, 0, 0));
    cyc(B, 0, '0,            0, 1, "tf_fl1",      ev(0, '0, 1, 0, 0, 0));
    cyc(B, 0, '0,            0, 1, "tf_fl2",      ev(0, '0, 1, 0, 0, 0));
    cyc(B, 0, '0,            0, 1, "tf_run",      ev(0, '0, 0, 0, 0, 0));
    cyc(B, 0, '0,            0, 1, "tf_bus",      ev(0, '0, 0, 1, 1, 0));
    cyc(B, 0, '0,            0, 0, "tf_drop",     ev(0, '0, 0, 1, 1, 0));
    cyc(B, 0, '0,            0, 0, "tf_rel",      ev(0, '0, 0, 0, 0, 0));

    // Five-cycle EX hold, jump serviced in the release cycle (dut_a)
    for (int i = 0; i < 5; i++)
      cyc(A, 0, '0, 1, 0, $sformatf("t3_hold%0d", i), ev(0, '0, 0, 1, 0, 0));
    cyc(A, 1, 32'h0000_0080, 0, 0, "t3_rel_jump", ev(1, 32'h80, 1, 0, 0, 0));
    cyc(A, 0, '0,            0, 0, "t3_idle",     ev(0, '0, 0, 0, 0, 0));

    // Runaway EX hold: 8 held cycles, then timeout and mask (dut_a)
    for (int i = 0; i < 8; i++)
      cyc(A, 0, '0, 1, 0, $sformatf("t4_hold%0d", i), ev(0, '0, 0, 1, 0, 0));
    cyc(A, 0, '0, 1, 0, "t4_fire",    ev(0, '0, 0, 0, 0, 0));
    cyc(A, 0, '0, 1, 0, "t4_mask0",   ev(0, '0, 0, 0, 0, 1));
    cyc(A, 0, '0, 1, 0, "t4_mask1",   ev(0, '0, 0, 0, 0, 1));
    cyc(A, 0, '0, 0, 0, "t4_low",     ev(0, '0, 0, 0, 0, 1));
    cyc(A, 0, '0, 1, 0, "t4_resume",  ev(0, '0, 0, 1, 0, 1));
    cyc(A, 0, '0, 0, 0, "t4_release", ev(0, '0, 0, 0, 0, 1));

    // Bus request during EX hold; jump ignored while frozen (dut_a)
    cyc(A, 0, '0,            1, 1, "t5_ex0",      ev(0, '0, 0, 1, 0, 1));
    cyc(A, 0, '0,            1, 1, "t5_ex1",      ev(0, '0, 0, 1, 0, 1));
    cyc(A, 0, '0,            0, 1, "t5_exrel",    ev(0, '0, 0, 0, 0, 1));
    cyc(A, 0, '0,            0, 1, "t5_run",      ev(0, '0, 0, 0, 0, 1));
    cyc(A, 0, '0,            0, 1, "t5_grant",    ev(0, '0, 0, 1, 1, 1));
    cyc(A, 1, 32'h0000_0300, 0, 1, "t5_nojump",   ev(0, '0, 0, 1, 1, 1));
    cyc(A, 0, '0,            0, 0, "t5_drop",     ev(0, '0, 0, 1, 1, 1));
    cyc(A, 0, '0,            0, 0, "t5_rel",      ev(0, '0, 0, 0, 0, 1));

    // Reset in BUS_HOLD clears grant, holds and sticky timeout (dut_a)
    cyc(A, 0, '0, 0, 1, "t6_run",  ev(0, '0, 0, 0, 0, 1));
    cyc(A, 0, '0, 0, 1, "t6_bus",  ev(0, '0, 0, 1, 1, 1));
    rst_pulse(A, "t6_rst_bus");
    cyc(A, 0, '0, 0, 0, "t6_post_a", ev(0, '0, 0, 0, 0, 0));

    // Reset in FLUSH drops flush immediately (dut_b)
    cyc(B, 1, 32'h0000_0400, 0, 0, "t6_jump",  ev(1, 32'h400, 1, 0, 0, 0));
    cyc(B, 0, '0,            0, 0, "t6_flush", ev(0, '0, 1, 0, 0, 0));
    rst_pulse(B, "t6_rst_flush");
    cyc(B, 0, '0, 0, 0, "t6_post_b", ev(0, '0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
